// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the unified memory port arbiter: load/store size
//   encodings, the arbiter FSM state and the owner tag used to route the
//   read response that arrives one cycle after each issue.
package mem_port_arbiter_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_LS   = 2'b10
  } owner_t;

  // A half must sit on an even address, a word (and the 11 encoding, which
  // behaves as a word) on a word boundary; bytes are always aligned.
  function automatic logic ls_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_ls_lane_align.sv
// mem_port_arbiter_ls_lane_align
//   Combinational lane steering for the load/store path. Memory lanes are
//   big-endian: the byte at the lowest address lives in bits [31:24].
// Ports:
//   st_size, st_off  store size and byte offset within the word
//   st_data          right-justified store data
//   be               byte strobes, be[3] = lane [31:24]
//   lane_wdata       store data replicated onto every candidate lane
//   ld_size, ld_off  size/offset of the load whose word is returning
//   ld_word          raw memory word
//   ld_data          extracted lane, right-justified and zero-extended
module mem_port_arbiter_ls_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  // Store strobes and replicated write data.
  always_comb begin
    be         = 4'b0000;
    lane_wdata = 32'h0000_0000;
    case (st_size)
      SZ_B: begin
        be         = 4'b1000 >> st_off;
        lane_wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        if (st_off[1]) begin
          be = 4'b0011;
        end else begin
          be = 4'b1100;
        end
        lane_wdata = {2{st_data[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        lane_wdata = st_data;
      end
    endcase
  end

  // Load lane extraction with zero extension.
  always_comb begin
    ld_data = 32'h0000_0000;
    case (ld_size)
      SZ_B: begin
        case (ld_off)
          2'b00:   ld_data = {24'h00_0000, ld_word[31:24]};
          2'b01:   ld_data = {24'h00_0000, ld_word[23:16]};
          2'b10:   ld_data = {24'h00_0000, ld_word[15:8]};
          default: ld_data = {24'h00_0000, ld_word[7:0]};
        endcase
      end
      SZ_H: begin
        if (ld_off[1]) begin
          ld_data = {16'h0000, ld_word[15:0]};
        end else begin
          ld_data = {16'h0000, ld_word[31:16]};
        end
      end
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Owns the single 32-bit port of the unified program/data memory.
//   Arbitrates instruction fetch (IF) against load/store (LS), splits
//   fetches that straddle a word boundary into two back-to-back reads,
//   and routes each read response (1-cycle latency) to its requester.
// Ports:
//   clk, rst                           clock, async active-high reset
//   if_req/if_addr/if_flush            fetch request side
//   if_gnt/if_rvalid/if_rdata          fetch grant and response
//   ls_req/ls_we/ls_size/ls_addr/ls_wdata   load/store request side
//   ls_gnt/ls_rvalid/ls_rdata/ls_err   load/store grant, response, misalign pulse
//   mem_en/mem_we/mem_addr/mem_wdata   memory command (word address)
//   mem_rdata                          memory read data, one cycle after mem_en
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int WA = ADDR_W - 2;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t        state, state_nx;
  logic [CW-1:0] starve_cnt;
  owner_t        resp_own, resp_own_nx;
  logic          resp_first, resp_first_nx;   // first half of a split returning
  logic          resp_second, resp_second_nx; // second half of a split returning
  logic [1:0]    resp_size;
  logic [1:0]    resp_off;
  logic [15:0]   hold;
  logic [WA-1:0] split_word;

  logic          if_win;
  logic          ls_mis;
  logic [3:0]    st_be;
  logic [31:0]   st_lane;
  logic [31:0]   ld_data;
  logic          unused_if_addr0;

  // Fetches are halfword aligned, so bit 0 never steers anything.
  assign unused_if_addr0 = if_addr[0];

  // LS wins contention until IF has been refused STARVE_LIMIT times; a flush
  // always blocks the fetch grant.
  assign if_win = if_req && !if_flush && !(ls_req && (starve_cnt < LIMIT));
  assign ls_mis = ls_misaligned(ls_size, ls_addr[1:0]);

  mem_port_arbiter_ls_lane_align u_align (
    .st_size    (ls_size),
    .st_off     (ls_addr[1:0]),
    .st_data    (ls_wdata),
    .be         (st_be),
    .lane_wdata (st_lane),
    .ld_size    (resp_size),
    .ld_off     (resp_off),
    .ld_word    (mem_rdata),
    .ld_data    (ld_data)
  );

  // Next-state, grant and memory command decode. Everything is held at zero
  // while rst is high so the port goes quiet immediately on an async reset.
  always_comb begin
    state_nx       = state;
    resp_own_nx    = OWN_NONE;
    resp_first_nx  = 1'b0;
    resp_second_nx = 1'b0;
    if_gnt         = 1'b0;
    ls_gnt         = 1'b0;
    ls_err         = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 4'b0000;
    mem_addr       = {WA{1'b0}};
    mem_wdata      = 32'h0000_0000;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (if_win) begin
            if_gnt      = 1'b1;
            mem_en      = 1'b1;
            mem_addr    = if_addr[ADDR_W-1:2];
            resp_own_nx = OWN_IF;
            if (if_addr[1]) begin
              state_nx      = ST_SPLIT;
              resp_first_nx = 1'b1;
            end else begin
              state_nx = ST_IDLE;
            end
          end else if (ls_req) begin
            ls_gnt = 1'b1;
            if (ls_mis) begin
              ls_err = 1'b1;
            end else begin
              mem_en   = 1'b1;
              mem_addr = ls_addr[ADDR_W-1:2];
              if (ls_we) begin
                mem_we    = st_be;
                mem_wdata = st_lane;
              end else begin
                resp_own_nx = OWN_LS;
              end
            end
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_SPLIT: begin
          // Not preemptible; a flush just abandons the second read.
          state_nx = ST_IDLE;
          if (!if_flush) begin
            mem_en         = 1'b1;
            mem_addr       = split_word;
            resp_own_nx    = OWN_IF;
            resp_second_nx = 1'b1;
          end else begin
            resp_own_nx = OWN_NONE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end else begin
      state_nx = ST_IDLE;
    end
  end

  // State, starvation counter and response-routing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      starve_cnt  <= {CW{1'b0}};
      resp_own    <= OWN_NONE;
      resp_first  <= 1'b0;
      resp_second <= 1'b0;
      resp_size   <= 2'b00;
      resp_off    <= 2'b00;
      hold        <= 16'h0000;
      split_word  <= {WA{1'b0}};
    end else begin
      state       <= state_nx;
      resp_own    <= resp_own_nx;
      resp_first  <= resp_first_nx;
      resp_second <= resp_second_nx;
      if (if_gnt) begin
        starve_cnt <= {CW{1'b0}};
      end else if (if_req && (starve_cnt < LIMIT)) begin
        starve_cnt <= starve_cnt + CW'(1);
      end else begin
        starve_cnt <= starve_cnt;
      end
      if (ls_gnt) begin
        resp_size <= ls_size;
        resp_off  <= ls_addr[1:0];
      end else begin
        resp_size <= resp_size;
        resp_off  <= resp_off;
      end
      // Word A+1 wraps naturally at the top of the word address space.
      if (if_gnt) begin
        split_word <= if_addr[ADDR_W-1:2] + WA'(1);
      end else begin
        split_word <= split_word;
      end
      // Low half of word A is the first parcel of a straddling fetch.
      if (resp_first) begin
        hold <= mem_rdata[15:0];
      end else begin
        hold <= hold;
      end
    end
  end

  // Response steering; data buses stay zero unless their valid is high.
  always_comb begin
    if_rvalid = (resp_own == OWN_IF) && !resp_first;
    ls_rvalid = (resp_own == OWN_LS);
    if_rdata  = 32'h0000_0000;
    ls_rdata  = 32'h0000_0000;
    if (if_rvalid) begin
      if (resp_second) begin
        if_rdata = {hold, mem_rdata[31:16]};
      end else begin
        if_rdata = mem_rdata;
      end
    end else begin
      if_rdata = 32'h0000_0000;
    end
    if (ls_rvalid) begin
      ls_rdata = ld_data;
    end else begin
      ls_rdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed self-checking bench for mem_port_arbiter with a simple
//   1-cycle-latency word memory model. Inputs change 1 time unit after the
//   rising edge; outputs are checked 2 units later, well before the next edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [11:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [11:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(12), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_size   (ls_size),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .ls_err    (ls_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Word memory: byte strobes on write, registered read data.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we[3]) mem[mem_addr][31:24] <= mem_wdata[31:24];
      if (mem_we[2]) mem[mem_addr][23:16] <= mem_wdata[23:16];
      if (mem_we[1]) mem[mem_addr][15:8]  <= mem_wdata[15:8];
      if (mem_we[0]) mem[mem_addr][7:0]   <= mem_wdata[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
    mem_rdata = 32'h0000_0000;
    rst      = 1'b1;
    if_req   = 1'b1;
    if_addr  = 12'h010;
    if_flush = 1'b0;
    ls_req   = 1'b1;
    ls_we    = 1'b0;
    ls_size  = 2'b10;
    ls_addr  = 12'h000;
    ls_wdata = 32'h0000_0000;

    // Reset: requests present but every output held low.
    settle();
    chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rst_ls_gnt", {31'd0, ls_gnt}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    cyc();
    cyc();
    rst    = 1'b0;
    if_req = 1'b0;
    ls_req = 1'b0;
    cyc();

    // Aligned fetch.
    mem[4]  = 32'h00A0_0093;
    if_req  = 1'b1;
    if_addr = 12'h010;
    settle();
    chk("al_gnt", {31'd0, if_gnt}, 32'd1);
    chk("al_mem_en", {31'd0, mem_en}, 32'd1);
    chk("al_mem_addr", {22'd0, mem_addr}, 32'h004);
    cyc();
    if_req = 1'b0;
    settle();
    chk("al_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("al_rdata", if_rdata, 32'h00A0_0093);
    cyc();

    // Split fetch with a load arriving during SPLIT.
    mem[4]  = 32'h1111_AAAA;
    mem[5]  = 32'hBBBB_2222;
    mem[0]  = 32'h1234_5678;
    if_req  = 1'b1;
    if_addr = 12'h012;
    settle();
    chk("sp_gnt", {31'd0, if_gnt}, 32'd1);
    chk("sp_addr_a", {22'd0, mem_addr}, 32'h004);
    cyc();
    if_req  = 1'b0;
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_size = 2'b10;
    ls_addr = 12'h000;
    settle();
    chk("sp_ls_wait", {31'd0, ls_gnt}, 32'd0);
    chk("sp_mem_en_b", {31'd0, mem_en}, 32'd1);
    chk("sp_addr_b", {22'd0, mem_addr}, 32'h005);
    chk("sp_no_early_rvalid", {31'd0, if_rvalid}, 32'd0);
    cyc();
    settle();
    chk("sp_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("sp_rdata", if_rdata, 32'hAAAA_BBBB);
    chk("sp_ls_gnt", {31'd0, ls_gnt}, 32'd1);
    chk("sp_ls_addr", {22'd0, mem_addr}, 32'h000);
    cyc();
    ls_req = 1'b0;
    settle();
    chk("sp_ls_rvalid", {31'd0, ls_rvalid}, 32'd1);
    chk("sp_ls_rdata", ls_rdata, 32'h1234_5678);
    chk("sp_if_quiet", {31'd0, if_rvalid}, 32'd0);
    cyc();

    // Wrap at the top of memory.
    mem[1023] = 32'hCAFE_0123;
    mem[0]    = 32'h4567_ABCD;
    if_req    = 1'b1;
    if_addr   = 12'hFFE;
    settle();
    chk("wr_addr_a", {22'd0, mem_addr}, 32'h3FF);
    cyc();
    if_req = 1'b0;
    settle();
    chk("wr_addr_b", {22'd0, mem_addr}, 32'h000);
    cyc();
    settle();
    chk("wr_rdata", if_rdata, 32'h0123_4567);
    cyc();

    // Contention: LS wins four times, then the starved fetch goes through.
    if_req  = 1'b1;
    if_addr = 12'h020;
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_size = 2'b10;
    ls_addr = 12'h040;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("ct_ls_gnt%0d", i), {31'd0, ls_gnt}, 32'd1);
      chk($sformatf("ct_if_deny%0d", i), {31'd0, if_gnt}, 32'd0);
      cyc();
    end
    settle();
    chk("ct_if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("ct_ls_deny", {31'd0, ls_gnt}, 32'd0);
    cyc();
    settle();
    chk("ct_cleared", {31'd0, ls_gnt}, 32'd1);
    chk("ct_if_rvalid", {31'd0, if_rvalid}, 32'd1);

    // Stores: byte, half, size 11 treated as word.
    if_req   = 1'b0;
    ls_we    = 1'b1;
    ls_size  = 2'b00;
    ls_addr  = 12'h103;
    ls_wdata = 32'h0000_005A;
    mem[64]  = 32'h0000_0000;
    settle();
    chk("sb_gnt", {31'd0, ls_gnt}, 32'd1);
    chk("sb_we", {28'd0, mem_we}, 32'h1);
    chk("sb_wdata", {24'd0, mem_wdata[7:0]}, 32'h5A);
    chk("sb_addr", {22'd0, mem_addr}, 32'h040);
    cyc();
    ls_size  = 2'b01;
    ls_addr  = 12'h102;
    ls_wdata = 32'h0000_BEEF;
    settle();
    chk("sb_mem", mem[64], 32'h0000_005A);
    chk("sb_no_rvalid", {31'd0, ls_rvalid}, 32'd0);
    chk("sh_we", {28'd0, mem_we}, 32'h3);
    chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    cyc();
    ls_size  = 2'b11;
    ls_addr  = 12'h104;
    ls_wdata = 32'h0102_0304;
    settle();
    chk("s11_we", {28'd0, mem_we}, 32'hF);
    cyc();

    // Loads: half then byte from DEADBEEF.
    mem[64] = 32'hDEAD_BEEF;
    ls_we   = 1'b0;
    ls_size = 2'b01;
    ls_addr = 12'h102;
    settle();
    chk("lh_gnt", {31'd0, ls_gnt}, 32'd1);
    chk("lh_we", {28'd0, mem_we}, 32'h0);
    cyc();
    ls_size = 2'b00;
    ls_addr = 12'h101;
    settle();
    chk("lh_rvalid", {31'd0, ls_rvalid}, 32'd1);
    chk("lh_rdata", ls_rdata, 32'h0000_BEEF);
    cyc();
    ls_req = 1'b0;
    settle();
    chk("lb_rdata", ls_rdata, 32'h0000_00AD);
    cyc();

    // Misaligned word.
    ls_req  = 1'b1;
    ls_size = 2'b10;
    ls_addr = 12'h102;
    settle();
    chk("mis_gnt", {31'd0, ls_gnt}, 32'd1);
    chk("mis_err", {31'd0, ls_err}, 32'd1);
    chk("mis_mem_en", {31'd0, mem_en}, 32'd0);
    cyc();
    ls_req = 1'b0;
    settle();
    chk("mis_err_pulse", {31'd0, ls_err}, 32'd0);
    chk("mis_no_rvalid", {31'd0, ls_rvalid}, 32'd0);
    cyc();

    // Flush during SPLIT.
    if_req  = 1'b1;
    if_addr = 12'h012;
    settle();
    chk("fl_gnt", {31'd0, if_gnt}, 32'd1);
    cyc();
    if_req   = 1'b0;
    if_flush = 1'b1;
    settle();
    chk("fl_no_second", {31'd0, mem_en}, 32'd0);
    chk("fl_if_gnt", {31'd0, if_gnt}, 32'd0);
    cyc();
    if_flush = 1'b0;
    if_req   = 1'b1;
    if_addr  = 12'h010;
    settle();
    chk("fl_no_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("fl_idle_gnt", {31'd0, if_gnt}, 32'd1);
    cyc();
    if_req = 1'b0;
    settle();
    chk("fl_next_rdata", if_rdata, 32'h1111_AAAA);
    cyc();

    // Reset in the middle of a split.
    if_req  = 1'b1;
    if_addr = 12'h012;
    settle();
    chk("rs_gnt", {31'd0, if_gnt}, 32'd1);
    cyc();
    if_req = 1'b0;
    rst    = 1'b1;
    #1;
    chk("rs_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rs_rvalid", {31'd0, if_rvalid}, 32'd0);
    cyc();
    rst = 1'b0;
    settle();
    chk("rs_quiet_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rs_quiet_mem_en", {31'd0, mem_en}, 32'd0);
    if_req  = 1'b1;
    if_addr = 12'h010;
    settle();
    chk("rs_idle_gnt", {31'd0, if_gnt}, 32'd1);
    chk("rs_idle_addr", {22'd0, mem_addr}, 32'h004);
    cyc();
    if_req = 1'b0;
    settle();
    chk("rs_after_rdata", if_rdata, 32'h1111_AAAA);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
